// File: rtl/chunked_comparator_if.sv
// Operand/result handshake bundle for chunked_comparator.
// master = producer/consumer side, slave = comparator side.
interface chunked_comparator_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             gt;
  logic             lt;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, eq, gt, lt, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, eq, gt, lt, busy
  );
endinterface

// File: rtl/chunked_comparator.sv
// Multi-cycle magnitude comparator: CHUNK bits per cycle, MSB chunk first.
// Optional CHUNKED_COMPARATOR_EARLY_EXIT_EN finishes on the first differing chunk.
module chunked_comparator #(
  parameter int WIDTH  = 16,
  parameter int CHUNK  = 4,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  chunked_comparator_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [IDX_W-1:0]   idx;
  logic               decided;
  logic               gt_r;
  logic               lt_r;

  logic [CHUNK-1:0]   chunk_a;
  logic [CHUNK-1:0]   chunk_b;
  logic [1:0]         chunk_cmp;
  logic               chunk_gt;
  logic               chunk_lt;
  logic               chunk_differs;
  logic               accept;
  logic               handshake;
  logic               run_exit;

  // Unsigned per-chunk magnitude compare; never subtracts, so no overflow.
  function automatic logic [1:0] cmp_chunk(input logic [CHUNK-1:0] x,
                                           input logic [CHUNK-1:0] y);
    cmp_chunk = {x > y, x < y};
  endfunction

  always_comb begin
    chunk_a = a_sr[WIDTH-1 -: CHUNK];
    chunk_b = b_sr[WIDTH-1 -: CHUNK];
    // Flipping the sign bit of the top chunk maps two's complement onto unsigned order.
    if ((SIGNED != 0) && (idx == '0)) begin
      chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
      chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
    end
    chunk_cmp     = cmp_chunk(chunk_a, chunk_b);
    chunk_gt      = chunk_cmp[1];
    chunk_lt      = chunk_cmp[0];
    chunk_differs = chunk_gt | chunk_lt;
  end

  assign accept    = (state == IDLE) && bus.in_valid;
  assign handshake = (state == DONE) && bus.out_ready;

`ifdef CHUNKED_COMPARATOR_EARLY_EXIT_EN
  assign run_exit = (idx == LAST_IDX) || (!decided && chunk_differs);
`else
  assign run_exit = (idx == LAST_IDX);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)    state_nxt = RUN;
      RUN:  if (run_exit)  state_nxt = DONE;
      DONE: if (handshake) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      idx     <= '0;
      decided <= 1'b0;
      gt_r    <= 1'b0;
      lt_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr    <= bus.a;
            b_sr    <= bus.b;
            idx     <= '0;
            decided <= 1'b0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
          end
        end
        RUN: begin
          a_sr <= a_sr << CHUNK;
          b_sr <= b_sr << CHUNK;
          idx  <= idx + IDX_W'(1);
          // Only the first differing chunk decides; later chunks are ignored.
          if (!decided && chunk_differs) begin
            decided <= 1'b1;
            gt_r    <= chunk_gt;
            lt_r    <= chunk_lt;
          end
        end
        DONE: begin
          if (handshake) begin
            decided <= 1'b0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
          end
        end
        default: begin
          decided <= 1'b0;
        end
      endcase
    end
  end

  // Outputs decode the state directly so an async reset clears them at once.
  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == RUN);
  assign bus.out_valid = (state == DONE);
  assign bus.gt        = bus.out_valid & gt_r;
  assign bus.lt        = bus.out_valid & lt_r;
  assign bus.eq        = bus.out_valid & ~gt_r & ~lt_r;

endmodule

// File: tb/tb_chunked_comparator.sv
// Directed bench for chunked_comparator: unsigned, signed and CHUNK==WIDTH instances.
module tb_chunked_comparator;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  chunked_comparator_if #(.WIDTH(16)) u_if ();
  chunked_comparator_if #(.WIDTH(16)) s_if ();
  chunked_comparator_if #(.WIDTH(16)) w_if ();

  chunked_comparator #(.WIDTH(16), .CHUNK(4),  .SIGNED(0)) dut_u (.clk(clk), .rst(rst), .bus(u_if));
  chunked_comparator #(.WIDTH(16), .CHUNK(4),  .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .bus(s_if));
  chunked_comparator #(.WIDTH(16), .CHUNK(16), .SIGNED(0)) dut_w (.clk(clk), .rst(rst), .bus(w_if));

  // Status vector: {in_ready, out_valid, eq, gt, lt, busy}
  localparam logic [5:0] ST_IDLE = 6'b100000;
  localparam logic [5:0] ST_RUN  = 6'b000001;
  localparam logic [5:0] DONE_EQ = 6'b011000;
  localparam logic [5:0] DONE_GT = 6'b010100;
  localparam logic [5:0] DONE_LT = 6'b010010;

  function automatic int lat(input int k);
`ifdef CHUNKED_COMPARATOR_EARLY_EXIT_EN
    return k;
`else
    return 4;
`endif
  endfunction

  task automatic drive(input int which, input logic v, input logic [15:0] av,
                       input logic [15:0] bv, input logic ordy);
    case (which)
      0: begin u_if.in_valid = v; u_if.a = av; u_if.b = bv; u_if.out_ready = ordy; end
      1: begin s_if.in_valid = v; s_if.a = av; s_if.b = bv; s_if.out_ready = ordy; end
      default: begin w_if.in_valid = v; w_if.a = av; w_if.b = bv; w_if.out_ready = ordy; end
    endcase
  endtask

  function automatic logic [5:0] obs(input int which);
    case (which)
      0: return {u_if.in_ready, u_if.out_valid, u_if.eq, u_if.gt, u_if.lt, u_if.busy};
      1: return {s_if.in_ready, s_if.out_valid, s_if.eq, s_if.gt, s_if.lt, s_if.busy};
      default: return {w_if.in_ready, w_if.out_valid, w_if.eq, w_if.gt, w_if.lt, w_if.busy};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic wait_valid(input int which, output int cnt);
    cnt = 0;
    while (obs(which)[4] !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  // Full transaction with out_ready held high; checks latency, result and return to IDLE.
  task automatic run_cmp(input int which, input logic [15:0] av, input logic [15:0] bv,
                         input int exp_lat, input logic [5:0] exp_res, input string tag);
    int cnt;
    @(negedge clk);
    check({tag, "_ready"}, obs(which), ST_IDLE);
    drive(which, 1'b1, av, bv, 1'b1);
    @(posedge clk); #1;
    drive(which, 1'b0, ~av, ~bv, 1'b1);
    check({tag, "_busy"}, obs(which), ST_RUN);
    wait_valid(which, cnt);
    check({tag, "_lat"}, cnt, exp_lat);
    check({tag, "_res"}, obs(which), exp_res);
    @(posedge clk); #1;
    check({tag, "_idle"}, obs(which), ST_IDLE);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b1);
    drive(1, 1'b0, 16'h0, 16'h0, 1'b1);
    drive(2, 1'b0, 16'h0, 16'h0, 1'b1);
    #12;
    check("rst_u", obs(0), ST_IDLE);
    check("rst_s", obs(1), ST_IDLE);
    check("rst_w", obs(2), ST_IDLE);
    @(negedge clk);
    rst = 1'b0;

    run_cmp(0, 16'h1234, 16'h1234, 4,      DONE_EQ, "u_eq");
    run_cmp(0, 16'h8000, 16'h7FFF, lat(1), DONE_GT, "u_8000");
    run_cmp(1, 16'h8000, 16'h7FFF, lat(1), DONE_LT, "s_8000");
    run_cmp(0, 16'h2000, 16'h1FFF, lat(1), DONE_GT, "u_2000");
    run_cmp(0, 16'h1230, 16'h1234, 4,      DONE_LT, "u_1230");
    run_cmp(0, 16'hFFFF, 16'h0000, lat(1), DONE_GT, "u_ones");
    run_cmp(1, 16'hFFFF, 16'h0001, lat(1), DONE_LT, "s_m1");
    run_cmp(1, 16'hFFFE, 16'hFFFF, 4,      DONE_LT, "s_fffe");
    run_cmp(1, 16'h7FFF, 16'h7FFF, 4,      DONE_EQ, "s_eq");

    // Result held under back-pressure while new operands are offered.
    @(negedge clk);
    drive(0, 1'b1, 16'h0005, 16'h0003, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    wait_valid(0, cnt);
    check("hold_lat", cnt, 4);
    check("hold_res", obs(0), DONE_GT);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(0, (i % 2) == 0, 16'h0001, 16'h0009, 1'b0);
      @(posedge clk); #1;
      check("hold_stable", obs(0), DONE_GT);
    end
    @(negedge clk);
    drive(0, 1'b0, 16'h0001, 16'h0009, 1'b1);
    @(posedge clk); #1;
    check("hold_release", obs(0), ST_IDLE);
    run_cmp(0, 16'h0001, 16'h0009, 4, DONE_LT, "after_hold");

    // Reset during the second RUN cycle.
    @(negedge clk);
    drive(0, 1'b1, 16'h1234, 16'h1235, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    @(posedge clk); #1;
    check("mid_busy", obs(0), ST_RUN);
    rst = 1'b1;
    #1;
    check("mid_rst_async", obs(0), ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_rel", obs(0), ST_IDLE);
    run_cmp(0, 16'h00FF, 16'h0100, lat(2), DONE_LT, "post_rst");

    // Single-chunk instance behaves as a registered comparator.
    run_cmp(2, 16'h0000, 16'hFFFF, 1, DONE_LT, "w_lt");
    run_cmp(2, 16'hABCD, 16'hABCD, 1, DONE_EQ, "w_eq");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
